alu_load_sequencer: RTL and testbench

- Front-end controller for the board-level ALU.
- Synchronises and debounces the push-buttons, then enforces a fixed load order: operand A, then operand B, then opcode, then execute.
- Drives the ALU operand and opcode registers, and latches the ALU result onto the LEDs with a valid flag.
- Sits between the board I/O (switches, buttons, LEDs) and the combinational ALU. Replaces direct button-to-register loading.

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/btn_debouncer.sv | 44 ++++
 rtl/alu_load_sequencer.sv | 113 +++++++++++
 tb/tb_alu_load_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encodings and button indices for the ALU load sequencer
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam int BTN_LOAD_A  = 0;
    localparam int BTN_LOAD_B  = 1;
    localparam int BTN_LOAD_OP = 2;
    localparam int BTN_CLEAR   = 3;

endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-FF synchroniser plus stable-level filter, emits a 1-cycle pulse on each accepted press
module btn_debouncer #(
    parameter int DBNC_MAX = 1000000,
    parameter int NB_DBNC  = $clog2(DBNC_MAX + 1)
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    logic [1:0]         sync_q;
    logic [NB_DBNC-1:0] cnt_q;
    logic [NB_DBNC-1:0] cnt_d;
    logic               level_q;
    logic               level_d;
    logic               press_q;
    logic               differ;
    logic               done;

    assign differ  = sync_q[1] ^ level_q;
    assign done    = differ && (cnt_q == NB_DBNC'(DBNC_MAX - 1));
    assign cnt_d   = (!differ || done) ? '0 : cnt_q + NB_DBNC'(1);
    assign level_d = level_q ^ done;
    assign o_level = level_q;
    assign o_press = press_q;

    // synchronise the raw button, count stable cycles, toggle the accepted level and flag rising toggles
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= done && !level_q;
        end
    end

endmodule

// File: rtl/alu_load_sequencer.sv
// alu_load_sequencer: debounced A -> B -> op -> execute load order for the board ALU; ALU_SEQ_AUTO_EXEC_EN enables re-execute on reload from S_SHOW
import alu_seq_pkg::*;

module alu_load_sequencer #(
    parameter int NB_DATA  = 6,
    parameter int NB_BTN   = 4,
    parameter int DBNC_MAX = 1000000
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic [NB_BTN-1:0]  i_btn,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_DATA-1:0] o_alu_op,
    output logic [NB_DATA-1:0] o_led,
    output logic               o_result_valid,
    output logic [2:0]         o_state
);

    localparam int NB_DBNC = $clog2(DBNC_MAX + 1);

    logic [NB_BTN-1:0]  pulse;
    logic [NB_BTN-1:0]  level;
    logic [NB_BTN-1:0]  press;
    state_t             state_q;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_DATA-1:0] op_q;
    logic [NB_DATA-1:0] led_q;
    logic               valid_q;

    for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
        btn_debouncer #(
            .DBNC_MAX(DBNC_MAX),
            .NB_DBNC (NB_DBNC)
        ) u_dbnc (
            .clock  (clock),
            .i_reset(i_reset),
            .i_btn  (i_btn[g]),
            .o_level(level[g]),
            .o_press(pulse[g])
        );
    end

    // a press pulse always coincides with a freshly accepted high level
    assign press = pulse & level;

    // load-order FSM; clear beats every other press, and only the press matching the state is taken
    always_ff @(posedge clock) begin
        if (i_reset || press[BTN_CLEAR]) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT_A: if (press[BTN_LOAD_A]) begin
                    a_q     <= i_sw;
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B: if (press[BTN_LOAD_B]) begin
                    b_q     <= i_sw;
                    state_q <= S_WAIT_OP;
                end
                S_WAIT_OP: if (press[BTN_LOAD_OP]) begin
                    op_q    <= i_sw;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    led_q   <= i_alu_result;
                    valid_q <= 1'b1;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
`ifdef ALU_SEQ_AUTO_EXEC_EN
                    if (press[BTN_LOAD_A]) begin
                        a_q     <= i_sw;
                        valid_q <= 1'b0;
                        state_q <= S_EXEC;
                    end else if (press[BTN_LOAD_B]) begin
                        b_q     <= i_sw;
                        valid_q <= 1'b0;
                        state_q <= S_EXEC;
                    end else if (press[BTN_LOAD_OP]) begin
                        op_q    <= i_sw;
                        valid_q <= 1'b0;
                        state_q <= S_EXEC;
                    end
`else
                    if (press[BTN_LOAD_A]) begin
                        a_q     <= i_sw;
                        valid_q <= 1'b0;
                        state_q <= S_WAIT_B;
                    end
`endif
                end
                default: state_q <= S_WAIT_A;
            endcase
        end
    end

    assign o_alu_a        = a_q;
    assign o_alu_b        = b_q;
    assign o_alu_op       = op_q;
    assign o_led          = led_q;
    assign o_result_valid = valid_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// tb_alu_load_sequencer: randomized bench with a press-level reference model for alu_load_sequencer
module tb_alu_load_sequencer;

    logic       clock;
    logic       i_reset;
    logic [5:0] i_sw;
    logic [3:0] i_btn;
    logic [5:0] i_alu_result;
    logic [5:0] o_alu_a;
    logic [5:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [5:0] o_led;
    logic       o_result_valid;
    logic [2:0] o_state;

    int total = 0;
    int bad   = 0;

    logic [5:0] ma, mb, mop, mled;
    logic       mvalid;
    logic [2:0] mst;

    alu_load_sequencer #(.NB_DATA(6), .NB_BTN(4), .DBNC_MAX(4)) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_sw          (i_sw),
        .i_btn         (i_btn),
        .i_alu_result  (i_alu_result),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_op      (o_alu_op),
        .o_led         (o_led),
        .o_result_valid(o_result_valid),
        .o_state       (o_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] alu(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

    function automatic void model_reset();
        ma = 0; mb = 0; mop = 0; mled = 0; mvalid = 0; mst = 0;
    endfunction

    // one accepted press of the buttons in m, with the execute step already completed
    function automatic void model_apply(input logic [3:0] m, input logic [5:0] sw);
        if (m[3]) begin
            model_reset();
        end else if (mst == 0 && m[0]) begin
            ma = sw; mst = 1;
        end else if (mst == 1 && m[1]) begin
            mb = sw; mst = 2;
        end else if (mst == 2 && m[2]) begin
            mop = sw; mled = alu(ma, mb, mop); mvalid = 1; mst = 4;
        end else if (mst == 4) begin
`ifdef ALU_SEQ_AUTO_EXEC_EN
            if (m[0]) ma = sw;
            else if (m[1]) mb = sw;
            else if (m[2]) mop = sw;
            if (m[2:0] != 0) begin
                mled = alu(ma, mb, mop); mvalid = 1; mst = 4;
            end
`else
            if (m[0]) begin
                ma = sw; mvalid = 0; mst = 1;
            end
`endif
        end
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_press(input logic [3:0] m, input logic [5:0] sw);
        i_sw  = sw;
        i_btn = m;
        repeat (8) cycle();
        i_btn = 4'b0;
        repeat (10) cycle();
        model_apply(m, sw);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_btn   = 4'b0;
        i_sw    = 6'h3f;
        repeat (2) cycle();
        i_reset = 1'b0;
        model_reset();
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state} !== 27'd0) begin
            bad++;
            $display("FAIL reset_state: a=%h b=%h op=%h led=%h v=%b st=%0d required all 0",
                     o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state);
        end
        do_press(4'b0001, 6'h2a);
        total++;
        if (o_alu_a !== 6'h2a || o_state !== 3'd1) begin
            bad++;
            $display("FAIL pre_reset_load: a=%h st=%0d required a=2a st=1", o_alu_a, o_state);
        end
        i_sw  = 6'h15;
        i_btn = 4'b0010;
        repeat (3) cycle();
        i_reset = 1'b1;
        i_btn   = 4'b0;
        cycle();
        i_reset = 1'b0;
        model_reset();
        repeat (10) cycle();
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state} !== 27'd0) begin
            bad++;
            $display("FAIL reset_mid_debounce: a=%h b=%h op=%h led=%h v=%b st=%0d required all 0",
                     o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state);
        end
    endtask

    task automatic test_full_sequence();
        bit seen;
        do_press(4'b0001, 6'h05);
        do_press(4'b0010, 6'h03);
        total++;
        if ({o_alu_a, o_alu_b, o_state} !== {6'h05, 6'h03, 3'd2}) begin
            bad++;
            $display("FAIL load_ab: a=%h b=%h st=%0d required a=05 b=03 st=2", o_alu_a, o_alu_b, o_state);
        end
        i_sw  = 6'h20;
        i_btn = 4'b0100;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (o_state === 3'd3) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL exec_state: st=%0d required 3 within 20 cycles", o_state);
        end else begin
            total++;
            if (o_alu_op !== 6'h20 || o_result_valid !== 1'b0) begin
                bad++;
                $display("FAIL exec_op: op=%h v=%b required op=20 v=0", o_alu_op, o_result_valid);
            end
            cycle();
            total++;
            if ({o_led, o_result_valid, o_state} !== {alu(6'h05, 6'h03, 6'h20), 1'b1, 3'd4}) begin
                bad++;
                $display("FAIL exec_result: led=%h v=%b st=%0d required led=%h v=1 st=4",
                         o_led, o_result_valid, o_state, alu(6'h05, 6'h03, 6'h20));
            end
        end
        i_btn = 4'b0;
        repeat (12) cycle();
        model_apply(4'b0100, 6'h20);
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state} !== {ma, mb, mop, mled, mvalid, mst}) begin
            bad++;
            $display("FAIL full_sequence: a=%h b=%h op=%h led=%h v=%b st=%0d required %h %h %h %h %b %0d",
                     o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state, ma, mb, mop, mled, mvalid, mst);
        end
    endtask

    task automatic test_glitch_order();
        do_press(4'b1000, 6'h00);
        i_sw  = 6'h2c;
        i_btn = 4'b0001;
        repeat (2) cycle();
        i_btn = 4'b0;
        repeat (10) cycle();
        i_btn = 4'b0001;
        repeat (3) cycle();
        i_btn = 4'b0;
        repeat (10) cycle();
        total++;
        if ({o_alu_a, o_state} !== {ma, mst}) begin
            bad++;
            $display("FAIL glitch: a=%h st=%0d required a=%h st=%0d", o_alu_a, o_state, ma, mst);
        end
        do_press(4'b0010, 6'h1b);
        total++;
        if ({o_alu_b, o_state} !== {mb, 3'd0}) begin
            bad++;
            $display("FAIL out_of_order: b=%h st=%0d required b=%h st=0", o_alu_b, o_state, mb);
        end
        i_sw  = 6'h19;
        i_btn = 4'b0001;
        repeat (4) cycle();
        i_btn = 4'b0;
        repeat (10) cycle();
        model_apply(4'b0001, 6'h19);
        total++;
        if ({o_alu_a, o_state} !== {ma, mst}) begin
            bad++;
            $display("FAIL min_hold_press: a=%h st=%0d required a=%h st=%0d", o_alu_a, o_state, ma, mst);
        end
    endtask

    task automatic test_clear_priority();
        do_press(4'b0010, 6'($urandom));
        total++;
        if (o_state !== 3'd2) begin
            bad++;
            $display("FAIL reach_wait_op: st=%0d required 2", o_state);
        end
        do_press(4'b1100, 6'($urandom));
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state} !== 27'd0) begin
            bad++;
            $display("FAIL clear_priority: a=%h b=%h op=%h led=%h v=%b st=%0d required all 0",
                     o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state);
        end
    endtask

    task automatic test_show_reload();
        logic [5:0] old_led;
        do_press(4'b0001, 6'($urandom));
        do_press(4'b0010, 6'($urandom));
        do_press(4'b0100, 6'($urandom));
        old_led = mled;
        total++;
        if ({o_led, o_result_valid, o_state} !== {mled, 1'b1, 3'd4}) begin
            bad++;
            $display("FAIL reach_show: led=%h v=%b st=%0d required led=%h v=1 st=4", o_led, o_result_valid, o_state, mled);
        end
        do_press(4'b0001, 6'h11);
        total++;
`ifdef ALU_SEQ_AUTO_EXEC_EN
        if ({o_alu_a, o_led, o_result_valid, o_state} !== {6'h11, mled, 1'b1, 3'd4}) begin
`else
        if ({o_alu_a, o_led, o_result_valid, o_state} !== {6'h11, old_led, 1'b0, 3'd1}) begin
`endif
            bad++;
            $display("FAIL show_reload: a=%h led=%h v=%b st=%0d required a=11 led=%h v=%b st=%0d",
                     o_alu_a, o_led, o_result_valid, o_state, mled, mvalid, mst);
        end
    endtask

`ifdef ALU_SEQ_AUTO_EXEC_EN
    task automatic test_auto_exec();
        bit seen;
        i_sw  = 6'h01;
        i_btn = 4'b0010;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (o_state === 3'd3) seen = 1;
        end
        total++;
        if (!seen || o_result_valid !== 1'b0 || o_alu_b !== 6'h01) begin
            bad++;
            $display("FAIL auto_exec_state: st=%0d v=%b b=%h required st=3 v=0 b=01", o_state, o_result_valid, o_alu_b);
        end
        cycle();
        i_btn = 4'b0;
        model_apply(4'b0010, 6'h01);
        total++;
        if ({o_led, o_result_valid, o_state} !== {mled, 1'b1, 3'd4}) begin
            bad++;
            $display("FAIL auto_exec_result: led=%h v=%b st=%0d required led=%h v=1 st=4", o_led, o_result_valid, o_state, mled);
        end
        repeat (12) cycle();
    endtask
`endif

    task automatic test_random();
        logic [3:0] m;
        logic [5:0] sw;
        for (int i = 0; i < 30; i++) begin
            m = 4'($urandom_range(1, 15));
            if (m[3] && $urandom_range(0, 3) != 0) m[3] = 1'b0;
            if (m == 4'b0) m = 4'b0001 << (i % 3);
            sw = 6'($urandom);
            do_press(m, sw);
            total++;
            if ({o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state} !== {ma, mb, mop, mled, mvalid, mst}) begin
                bad++;
                $display("FAIL random_%0d: btn=%b a=%h b=%h op=%h led=%h v=%b st=%0d required %h %h %h %h %b %0d",
                         i, m, o_alu_a, o_alu_b, o_alu_op, o_led, o_result_valid, o_state, ma, mb, mop, mled, mvalid, mst);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_btn   = 4'b0;
        i_sw    = 6'h0;
        model_reset();
        test_reset();
        test_full_sequence();
        test_glitch_order();
        test_clear_priority();
        test_show_reload();
`ifdef ALU_SEQ_AUTO_EXEC_EN
        do_press(4'b1000, 6'h00);
        do_press(4'b0001, 6'($urandom));
        do_press(4'b0010, 6'($urandom));
        do_press(4'b0100, 6'($urandom));
        test_auto_exec();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
